// File: rtl/bcd_counter_display.sv
// DIGITS-wide BCD up/down counter with tick divider, load, wrap/saturate mode and a
// time-multiplexed common-anode 7-segment driver with optional leading-zero blanking.
module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int SCAN_DIV = 1000,
    parameter int LZB      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  upDown,
    input  logic                  satMode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadVal,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg7,
    output logic [DIGITS-1:0]     an
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'd9}};

    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [6:0]            seg7_q, seg7_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  tick;
    logic                  scan_adv;
    logic [4*DIGITS-1:0]   inc_val, dec_val, clamp_val;
    logic                  all_nine, all_zero, carry, borrow;
    logic [3:0]            cur_digit;
    logic                  blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TW'(CLK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        scan_adv   = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d = scan_adv ? '0 : scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_adv) begin
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
    end

    // Ripple increment/decrement and load clamping, one digit at a time from digit 0.
    always_comb begin
        inc_val   = count_q;
        dec_val   = count_q;
        clamp_val = loadVal;
        carry     = 1'b1;
        borrow    = 1'b1;
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (loadVal[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = clamp_val;
        end else if (tick && enable) begin
            if (upDown) begin
                if (!all_nine) begin
                    count_d = inc_val;
                end else if (!satMode) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!all_zero) begin
                    count_d = dec_val;
                end else if (!satMode) begin
                    count_d = ALL_NINES;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // A digit above 0 is blank when it and every higher digit are zero.
    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == scan_idx_q) begin
                cur_digit = count_q[4*i +: 4];
                blank     = (LZB != 0) && (i > 0) && ((count_q >> (4*i)) == '0);
            end
        end
        seg7_d = blank ? 7'b1111111 : seg_decode(cur_digit);
        an_d   = '1;
        an_d[scan_idx_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            seg7_q     <= 7'b1111111;
            an_q       <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            seg7_q     <= seg7_d;
            an_q       <= an_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg7  = seg7_q;
    assign an    = an_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: directed scenarios plus random traffic, checked every
// cycle against an integer-arithmetic model of the counter and display scan.
module tb_bcd_counter_display;
    localparam int DIGITS   = 2;
    localparam int CLK_DIV  = 4;
    localparam int SCAN_DIV = 2;
    localparam int MAXV     = 10**DIGITS - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, upDown = 1'b0, satMode = 1'b0, load = 1'b0;
    logic [4*DIGITS-1:0] loadVal = '0;

    logic [4*DIGITS-1:0] count_l, count_n;
    logic                wrap_l, wrap_n;
    logic [6:0]          seg_l, seg_n;
    logic [DIGITS-1:0]   an_l, an_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int                m_val  = 0;
    int                m_k    = 0;
    logic              m_wrap = 1'b0;
    logic [DIGITS-1:0] m_an   = '1;
    logic [6:0]        m_seg_l = 7'h7F;
    logic [6:0]        m_seg_n = 7'h7F;

    always #5 clk = ~clk;

    bcd_counter_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV), .LZB(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .satMode(satMode),
        .load(load), .loadVal(loadVal), .count(count_l), .wrap(wrap_l), .seg7(seg_l), .an(an_l)
    );

    bcd_counter_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV), .LZB(0)) u_dut_nolzb (
        .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .satMode(satMode),
        .load(load), .loadVal(loadVal), .count(count_n), .wrap(wrap_n), .seg7(seg_n), .an(an_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [4*DIGITS-1:0] x);
        int r, p, d;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(x[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    // Model advances on each rising edge using the inputs that are stable across it.
    always @(posedge clk) begin
        int idx, p, dig;
        bit tk;
        if (!rst) begin
            m_val = 0; m_k = 0; m_wrap = 1'b0;
            m_an = '1; m_seg_l = 7'h7F; m_seg_n = 7'h7F;
        end else begin
            idx = (m_k / SCAN_DIV) % DIGITS;
            p   = 10**idx;
            dig = (m_val / p) % 10;
            m_an = '1;
            m_an[idx] = 1'b0;
            m_seg_n = seg_of(dig);
            m_seg_l = (idx > 0 && m_val < p) ? 7'h7F : seg_of(dig);
            tk = ((m_k % CLK_DIV) == CLK_DIV - 1);
            m_wrap = 1'b0;
            if (load) begin
                m_val = from_bcd_clamped(loadVal);
            end else if (tk && enable) begin
                if (upDown) begin
                    if (m_val < MAXV) m_val++;
                    else if (!satMode) begin m_val = 0; m_wrap = 1'b1; end
                end else begin
                    if (m_val > 0) m_val--;
                    else if (!satMode) begin m_val = MAXV; m_wrap = 1'b1; end
                end
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("count", count_l, to_bcd(m_val));
            check_eq("wrap", wrap_l, m_wrap);
            check_eq("an", an_l, m_an);
            check_eq("seg7", seg_l, m_seg_l);
            check_eq("count_nolzb", count_n, to_bcd(m_val));
            check_eq("wrap_nolzb", wrap_n, m_wrap);
            check_eq("an_nolzb", an_n, m_an);
            check_eq("seg7_nolzb", seg_n, m_seg_n);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        @(negedge clk);
        load = 1'b1;
        loadVal = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int wraps;
        bit saw99;
        bit seen_d0, seen_d1;

        // Reset held for two edges
        cycles(2);
        chk_en = 1'b1;
        check_eq("rst_count", count_l, 8'h00);
        check_eq("rst_an", an_l, 2'b11);
        check_eq("rst_seg7", seg_l, 7'h7F);
        rst = 1'b1;
        cycles(1);
        check_eq("first_an", an_l, 2'b10);

        // Up count through 99 to 00 with wrap
        enable = 1'b1; upDown = 1'b1; satMode = 1'b0;
        do_load(8'h98);
        wraps = 0; saw99 = 1'b0;
        for (int i = 0; i < 20 && count_l != 8'h00; i++) begin
            @(negedge clk);
            if (count_l == 8'h99) saw99 = 1'b1;
            if (wrap_l) wraps++;
        end
        check_eq("up_reach_00", count_l, 8'h00);
        check_eq("up_saw_99", saw99, 1'b1);
        for (int i = 0; i < 3*CLK_DIV; i++) begin
            @(negedge clk);
            if (wrap_l) wraps++;
        end
        check_eq("up_wrap_pulses", wraps, 1);

        // Down with saturate, then down with wrap
        upDown = 1'b0; satMode = 1'b1;
        do_load(8'h01);
        wraps = 0;
        for (int i = 0; i < 6*CLK_DIV; i++) begin
            @(negedge clk);
            if (wrap_l) wraps++;
        end
        check_eq("sat_hold_00", count_l, 8'h00);
        check_eq("sat_no_wrap", wraps, 0);
        satMode = 1'b0;
        for (int i = 0; i < 20 && count_l != 8'h99; i++) begin
            @(negedge clk);
            if (wrap_l) wraps++;
        end
        check_eq("down_wrap_99", count_l, 8'h99);
        for (int i = 0; i < 2*CLK_DIV; i++) begin
            @(negedge clk);
            if (wrap_l) wraps++;
        end
        check_eq("down_wrap_pulses", wraps, 1);

        // Load with clamping on the same edge as a tick
        upDown = 1'b1;
        for (int i = 0; i < CLK_DIV && (m_k % CLK_DIV) != CLK_DIV - 1; i++) @(negedge clk);
        check_eq("tick_phase", m_k % CLK_DIV, CLK_DIV - 1);
        load = 1'b1; loadVal = 8'hF3;
        @(negedge clk);
        load = 1'b0;
        check_eq("load_clamp", count_l, 8'h93);

        // Leading zero blanking on 07
        enable = 1'b0;
        do_load(8'h07);
        cycles(1);
        seen_d0 = 1'b0; seen_d1 = 1'b0;
        for (int i = 0; i < 2*SCAN_DIV*DIGITS; i++) begin
            @(negedge clk);
            if (an_l == 2'b10) begin
                seen_d0 = 1'b1;
                check_eq("lzb_d0", seg_l, 7'b1111000);
            end
            if (an_l == 2'b01) begin
                seen_d1 = 1'b1;
                check_eq("lzb_d1", seg_l, 7'b1111111);
                check_eq("nolzb_d1", seg_n, 7'b1000000);
            end
        end
        check_eq("scan_saw_both", {seen_d1, seen_d0}, 2'b11);

        // Reset mid-count
        enable = 1'b1; upDown = 1'b1;
        do_load(8'h45);
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_count", count_l, 8'h00);
        check_eq("midrst_wrap", wrap_l, 1'b0);
        check_eq("midrst_an", an_l, 2'b11);
        rst = 1'b1;
        cycles(CLK_DIV - 1);
        check_eq("resume_hold", count_l, 8'h00);
        cycles(1);
        check_eq("resume_step", count_l, 8'h01);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) != 0);
            load    = ($urandom_range(0, 19) == 0);
            loadVal = 8'($urandom_range(0, 255));
            enable  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) upDown = ~upDown;
            if ($urandom_range(0, 63) == 0) satMode = ~satMode;
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
